// File: rtl/wb_arbiter_if.sv
// Writeback bus between the execution units and the arbiter's commit port.
// master: arbiter side (drives acks and the commit port).
// slave : unit/consumer side.
interface wb_arbiter_if #(
   parameter int NUM_UNITS = 3,
   parameter int ID_WIDTH  = 3
);
   localparam int UW = $clog2(NUM_UNITS);

   logic [NUM_UNITS-1:0]               unit_done;
   logic [NUM_UNITS-1:0][ID_WIDTH-1:0] unit_id;
   logic [NUM_UNITS-1:0][31:0]         unit_rd;
   logic [NUM_UNITS-1:0]               unit_ack;
   logic                               wb_valid;
   logic [ID_WIDTH-1:0]                wb_id;
   logic [31:0]                        wb_data;
   logic [UW-1:0]                      wb_unit;
   logic                               wb_ready;

   modport master (
      input  unit_done, unit_id, unit_rd, wb_ready,
      output unit_ack, wb_valid, wb_id, wb_data, wb_unit
   );

   modport slave (
      output unit_done, unit_id, unit_rd, wb_ready,
      input  unit_ack, wb_valid, wb_id, wb_data, wb_unit
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one completed execution unit per cycle, acks it
// combinationally and registers its id/result into a single commit port.
// Build option: WB_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it a fixed lowest-index-wins priority is used.
module wb_arbiter #(
   parameter int NUM_UNITS = 3,
   parameter int ID_WIDTH  = 3
) (
   input logic          clk,
   input logic          rst,
   wb_arbiter_if.master bus
);
   localparam int UW = $clog2(NUM_UNITS);

   logic          slot_free;
   logic          any_grant;
   logic [UW-1:0] grant;

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic [UW-1:0] last_grant;
   // one extra bit so last_grant+offset (at most 2*NUM_UNITS-1) never overflows
   logic [UW:0]   cand;
`endif

   // Select the winning unit; no path from unit_id/unit_rd
   always_comb begin
      slot_free = ~bus.wb_valid | bus.wb_ready;
      any_grant = 1'b0;
      grant     = '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_UNITS; i++) begin
         cand = {1'b0, last_grant} + (UW+1)'(i);
         if (cand >= (UW+1)'(NUM_UNITS))
            cand = cand - (UW+1)'(NUM_UNITS);
         if (!any_grant && bus.unit_done[cand[UW-1:0]]) begin
            any_grant = 1'b1;
            grant     = cand[UW-1:0];
         end
      end
`else
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         if (!any_grant && bus.unit_done[UW'(i)]) begin
            any_grant = 1'b1;
            grant     = UW'(i);
         end
      end
`endif
   end

   // One-hot ack, suppressed while the slot is blocked or reset is held
   always_comb begin
      bus.unit_ack = '0;
      if (slot_free && any_grant && !rst)
         bus.unit_ack[grant] = 1'b1;
   end

   // Commit port: load on ack, retire on ready, hold under backpressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.wb_valid <= 1'b0;
         bus.wb_id    <= '0;
         bus.wb_data  <= '0;
         bus.wb_unit  <= '0;
      end else if (slot_free) begin
         if (any_grant) begin
            bus.wb_valid <= 1'b1;
            bus.wb_id    <= bus.unit_id[grant];
            bus.wb_data  <= bus.unit_rd[grant];
            bus.wb_unit  <= grant;
         end else begin
            bus.wb_valid <= 1'b0;
         end
      end
   end

`ifdef WB_ARB_ROUND_ROBIN_EN
   // Remember the last winner so the search starts just past it
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= UW'(NUM_UNITS - 1);
      else if (slot_free && any_grant)
         last_grant <= grant;
   end
`endif
endmodule
